// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes, FSM states, op classes.
package alu_muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_MOVE, OP_NONE} op_class_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Unsigned radix-2 datapath: shift/add multiply and restoring divide, one step per enable.
module alu_muldiv_iter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] a_mag,
  input  logic [DATA_WIDTH-1:0] b_mag,
  output logic [DATA_WIDTH-1:0] upper,
  output logic [DATA_WIDTH-1:0] lower,
  output logic                  mul_last
);

  localparam int unsigned W = DATA_WIDTH;

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplr_q, mplr_d;
  logic           div_q;
  logic [W:0]     rem_sh;
  logic [W-1:0]   rem_diff;
  logic           rem_ge;

  // Divide: acc holds {remainder, dividend/quotient}; mcand low half holds the divisor.
  assign rem_sh   = acc_q[2*W-1:W-1];
  assign rem_ge   = rem_sh >= {1'b0, mcand_q[W-1:0]};
  assign rem_diff = rem_sh[W-1:0] - mcand_q[W-1:0];

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    if (load) begin
      mplr_d = b_mag;
      if (is_div) begin
        acc_d   = {{W{1'b0}}, a_mag};
        mcand_d = {{W{1'b0}}, b_mag};
      end else begin
        acc_d   = '0;
        mcand_d = {{W{1'b0}}, a_mag};
      end
    end else if (step) begin
      if (div_q) begin
        acc_d = {(rem_ge ? rem_diff : rem_sh[W-1:0]), acc_q[W-2:0], rem_ge};
      end else begin
        if (mplr_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      div_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      if (load) div_q <= is_div;
    end
  end

  assign upper    = acc_q[2*W-1:W];
  assign lower    = acc_q[W-1:0];
  // The step in progress consumes the last set multiplier bit.
  assign mul_last = ~|mplr_q[W-1:1];

endmodule

// File: rtl/alu_muldiv.sv
// MIPS HI/LO unit: iterative MULT/MULTU/DIV/DIVU plus MFHI/MFLO/MTHI/MTLO over valid/ready.
// Define ALU_MULDIV_EARLY_TERM_EN to end multiplies once the multiplier magnitude is exhausted.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FUNC_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FUNC_WIDTH-1:0] func,
  input  logic [DATA_WIDTH-1:0] op_A,
  input  logic [DATA_WIDTH-1:0] op_B,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_by_zero
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(W);
`ifdef ALU_MULDIV_EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  state_e         state;
  op_class_e      opc;
  logic [CntW-1:0] cnt;
  logic           sgn, accept;
  logic           is_div_q, neg_q, neg_r, b_zero_q;
  logic [W-1:0]   a_q, a_mag, b_mag, upper, lower, quo, rem;
  logic [2*W-1:0] prod_raw, prod;
  logic           mul_last;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    opc = OP_NONE;
    sgn = (func == FUNC_WIDTH'(FN_MULT)) || (func == FUNC_WIDTH'(FN_DIV));
    case (func)
      FUNC_WIDTH'(FN_MULT), FUNC_WIDTH'(FN_MULTU): opc = OP_MUL;
      FUNC_WIDTH'(FN_DIV),  FUNC_WIDTH'(FN_DIVU):  opc = OP_DIV;
      FUNC_WIDTH'(FN_MFHI), FUNC_WIDTH'(FN_MTHI),
      FUNC_WIDTH'(FN_MFLO), FUNC_WIDTH'(FN_MTLO):  opc = OP_MOVE;
      default: ;
    endcase
  end

  assign a_mag = (sgn && op_A[W-1]) ? -op_A : op_A;
  assign b_mag = (sgn && op_B[W-1]) ? -op_B : op_B;

  alu_muldiv_iter #(
    .DATA_WIDTH(W)
  ) u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (accept && (opc == OP_MUL || opc == OP_DIV)),
    .step    (state == RUN),
    .is_div  (opc == OP_DIV),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .upper   (upper),
    .lower   (lower),
    .mul_last(mul_last)
  );

  // Signed correction applied in FIX; remainder follows the dividend's sign.
  assign prod_raw = {upper, lower};
  assign prod     = neg_q ? -prod_raw : prod_raw;
  assign quo      = neg_q ? -lower : lower;
  assign rem      = neg_r ? -upper : upper;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      result      <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      is_div_q    <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_zero_q    <= 1'b0;
      a_q         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          div_by_zero <= 1'b0;
          unique case (opc)
            OP_MOVE: begin
              done <= 1'b1;
              if (func == FUNC_WIDTH'(FN_MTHI)) hi <= op_A;
              if (func == FUNC_WIDTH'(FN_MTLO)) lo <= op_A;
              if (func == FUNC_WIDTH'(FN_MFHI)) result <= hi;
              if (func == FUNC_WIDTH'(FN_MFLO)) result <= lo;
            end
            OP_MUL, OP_DIV: begin
              is_div_q <= (opc == OP_DIV);
              neg_q    <= sgn && (op_A[W-1] ^ op_B[W-1]);
              neg_r    <= sgn && op_A[W-1];
              b_zero_q <= (op_B == '0);
              a_q      <= op_A;
              cnt      <= '0;
              state    <= (EarlyTerm && opc == OP_MUL && op_B == '0) ? FIX : RUN;
            end
            default: ;
          endcase
        end
        RUN: begin
          cnt <= cnt + CntW'(1);
          if (cnt == CntW'(W - 1) || (EarlyTerm && !is_div_q && mul_last)) state <= FIX;
        end
        FIX: begin
          state       <= IDLE;
          done        <= 1'b1;
          div_by_zero <= is_div_q && b_zero_q;
          if (!is_div_q) begin
            {hi, lo} <= prod;
          end else if (b_zero_q) begin
            hi <= a_q;
            lo <= '1;
          end else begin
            hi <= rem;
            lo <= quo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
